// File: rtl/ctrl_pipe.sv
// Pipelined main control for the five-stage MIPS core: ID decode plus ID/EX, EX/MEM
// and MEM/WB control registers, with bubble insertion and a multi-cycle MULT hold in EX.
module ctrl_pipe #(
  parameter int MUL_LAT = 4,
  parameter bit EN_MUL  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       valid_i,
  input  logic       hazard_stall_i,
  input  logic       flush_i,
  output logic       jump_o,
  output logic       branch_o,
  output logic [3:0] ex_ctrl_o,
  output logic       ex_mul_o,
  output logic [1:0] mem_ctrl_o,
  output logic [1:0] wb_ctrl_o,
  output logic       busy_o,
  output logic       illegal_o
);

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  logic [1:0] dec_wb, dec_mem;
  logic [3:0] dec_ex;
  logic       dec_mul, dec_ill;

  logic [1:0] id_ex_wb_q, id_ex_wb_d, id_ex_mem_q, id_ex_mem_d;
  logic [3:0] id_ex_ex_q, id_ex_ex_d;
  logic       id_ex_mul_q, id_ex_mul_d, id_ex_ill_q, id_ex_ill_d;
  logic [1:0] ex_mem_wb_q, ex_mem_wb_d, ex_mem_mem_q, ex_mem_mem_d;
  logic [1:0] mem_wb_wb_q, mem_wb_wb_d;
  logic [3:0] cnt_q, cnt_d;
  logic       id_go;

  // wb = {RegWrite, MemtoReg}, mem = {MemRead, MemWrite}, ex = {ALUSrc, ALUOp, RegDst}
  always_comb begin
    dec_wb  = 2'b00;
    dec_mem = 2'b00;
    dec_ex  = 4'b0000;
    dec_mul = 1'b0;
    dec_ill = 1'b0;
    case (op_i)
      6'b000000: begin
        dec_wb  = 2'b10;
        dec_ex  = 4'b0111;
        dec_mul = EN_MUL && (funct_i == 6'b011000);
      end
      6'b001101: begin dec_wb = 2'b10; dec_ex = 4'b1100; end
      6'b001000: begin dec_wb = 2'b10; dec_ex = 4'b1000; end
      6'b100011: begin dec_wb = 2'b11; dec_mem = 2'b10; dec_ex = 4'b1000; end
      6'b101011: begin dec_mem = 2'b01; dec_ex = 4'b1000; end
      6'b000100: dec_ex = 4'b0010;
      6'b000010: ;
      default:   dec_ill = 1'b1;
    endcase
  end

  assign busy_o   = id_ex_mul_q && (cnt_q < CNT_LAST);
  assign id_go    = valid_i & ~busy_o & ~flush_i;
  assign jump_o   = id_go & (op_i == 6'b000010);
  assign branch_o = id_go & (op_i == 6'b000100);

  always_comb begin
    id_ex_wb_d  = id_ex_wb_q;
    id_ex_mem_d = id_ex_mem_q;
    id_ex_ex_d  = id_ex_ex_q;
    id_ex_mul_d = id_ex_mul_q;
    id_ex_ill_d = id_ex_ill_q;
    // flush/stall are only honoured once the MULT releases EX
    if (!busy_o) begin
      if (flush_i || hazard_stall_i || !valid_i) begin
        id_ex_wb_d  = 2'b00;
        id_ex_mem_d = 2'b00;
        id_ex_ex_d  = 4'b0000;
        id_ex_mul_d = 1'b0;
        id_ex_ill_d = 1'b0;
      end else begin
        id_ex_wb_d  = dec_wb;
        id_ex_mem_d = dec_mem;
        id_ex_ex_d  = dec_ex;
        id_ex_mul_d = dec_mul;
        id_ex_ill_d = dec_ill;
      end
    end
    ex_mem_wb_d  = busy_o ? 2'b00 : id_ex_wb_q;
    ex_mem_mem_d = busy_o ? 2'b00 : id_ex_mem_q;
    mem_wb_wb_d  = ex_mem_wb_q;
    cnt_d        = busy_o ? cnt_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_ex_wb_q   <= 2'b00;
      id_ex_mem_q  <= 2'b00;
      id_ex_ex_q   <= 4'b0000;
      id_ex_mul_q  <= 1'b0;
      id_ex_ill_q  <= 1'b0;
      ex_mem_wb_q  <= 2'b00;
      ex_mem_mem_q <= 2'b00;
      mem_wb_wb_q  <= 2'b00;
      cnt_q        <= 4'd0;
    end else begin
      id_ex_wb_q   <= id_ex_wb_d;
      id_ex_mem_q  <= id_ex_mem_d;
      id_ex_ex_q   <= id_ex_ex_d;
      id_ex_mul_q  <= id_ex_mul_d;
      id_ex_ill_q  <= id_ex_ill_d;
      ex_mem_wb_q  <= ex_mem_wb_d;
      ex_mem_mem_q <= ex_mem_mem_d;
      mem_wb_wb_q  <= mem_wb_wb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_ctrl_o  = id_ex_ex_q;
  assign ex_mul_o   = id_ex_mul_q;
  assign illegal_o  = id_ex_ill_q;
  assign mem_ctrl_o = ex_mem_mem_q;
  assign wb_ctrl_o  = mem_wb_wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares them; a second instance has the MULT decode disabled.
module tb_ctrl_pipe;

  localparam int K_EX = 0, K_MEM = 1, K_WB = 2, K_BUSY = 3, K_ILL = 4;
  localparam int K_BR = 5, K_J = 6, K_MUL = 7, K_BUSY2 = 8, K_MUL2 = 9;

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] F_MULT = 6'b011000, F_ADD = 6'b100000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i, funct_i;
  logic       valid_i, hazard_stall_i, flush_i;
  logic       jump_o, branch_o, ex_mul_o, busy_o, illegal_o;
  logic [3:0] ex_ctrl_o;
  logic [1:0] mem_ctrl_o, wb_ctrl_o;
  logic       jump2, branch2, ex_mul2, busy2, illegal2;
  logic [3:0] ex_ctrl2;
  logic [1:0] mem_ctrl2, wb_ctrl2;

  ctrl_pipe #(.MUL_LAT(4), .EN_MUL(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i), .valid_i(valid_i),
    .hazard_stall_i(hazard_stall_i), .flush_i(flush_i), .jump_o(jump_o),
    .branch_o(branch_o), .ex_ctrl_o(ex_ctrl_o), .ex_mul_o(ex_mul_o),
    .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o), .busy_o(busy_o), .illegal_o(illegal_o));

  ctrl_pipe #(.MUL_LAT(4), .EN_MUL(1'b0)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct_i(funct_i), .valid_i(valid_i),
    .hazard_stall_i(hazard_stall_i), .flush_i(flush_i), .jump_o(jump2),
    .branch_o(branch2), .ex_ctrl_o(ex_ctrl2), .ex_mul_o(ex_mul2),
    .mem_ctrl_o(mem_ctrl2), .wb_ctrl_o(wb_ctrl2), .busy_o(busy2), .illegal_o(illegal2));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; logic [3:0] val; } exp_t;
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  function automatic string kname(int k);
    case (k)
      K_EX: return "ex_ctrl";   K_MEM: return "mem_ctrl"; K_WB: return "wb_ctrl";
      K_BUSY: return "busy";    K_ILL: return "illegal";  K_BR: return "branch";
      K_J: return "jump";       K_MUL: return "ex_mul";   K_BUSY2: return "busy_nomul";
      default: return "ex_mul_nomul";
    endcase
  endfunction

  function automatic logic [3:0] observe(int k);
    case (k)
      K_EX:    return ex_ctrl_o;
      K_MEM:   return {2'b00, mem_ctrl_o};
      K_WB:    return {2'b00, wb_ctrl_o};
      K_BUSY:  return {3'b000, busy_o};
      K_ILL:   return {3'b000, illegal_o};
      K_BR:    return {3'b000, branch_o};
      K_J:     return {3'b000, jump_o};
      K_MUL:   return {3'b000, ex_mul_o};
      K_BUSY2: return {3'b000, busy2};
      default: return {3'b000, ex_mul2};
    endcase
  endfunction

  task automatic exp_at(int dc, int kind, logic [3:0] v);
    exp_t e;
    e.cyc = cyc + dc; e.kind = kind; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, want);
    end
  endtask

  // Monitor: pop every expectation due this cycle; anything overdue counts as missed.
  always @(negedge clk_i) begin
    logic [3:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        act = observe(sb_q[i].kind);
        checks++;
        if (sb_q[i].cyc < cyc || act !== sb_q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%b expected=%b", kname(sb_q[i].kind),
                   sb_q[i].cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic drive(logic [5:0] op, logic [5:0] fn, logic v, logic st, logic fl);
    op_i = op; funct_i = fn; valid_i = v; hazard_stall_i = st; flush_i = fl;
  endtask

  task automatic idle();
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ex_ctrl", ex_ctrl_o, 4'b0000);
    chk("reset_mem_ctrl", {2'b00, mem_ctrl_o}, 4'b0000);
    chk("reset_wb_ctrl", {2'b00, wb_ctrl_o}, 4'b0000);
    chk("reset_busy", {3'b000, busy_o}, 4'b0000);
    chk("reset_illegal", {3'b000, illegal_o}, 4'b0000);
    chk("reset_ex_mul", {3'b000, ex_mul_o}, 4'b0000);
    rst_i = 1'b0;
    tick();

    // lw, sw, addi back to back
    drive(OP_LW, 6'd0, 1, 0, 0);
    exp_at(1, K_EX, 4'b1000); exp_at(2, K_MEM, 4'b0010); exp_at(3, K_WB, 4'b0011);
    tick();
    drive(OP_SW, 6'd0, 1, 0, 0);
    exp_at(1, K_EX, 4'b1000); exp_at(2, K_MEM, 4'b0001); exp_at(3, K_WB, 4'b0000);
    tick();
    drive(OP_ADDI, 6'd0, 1, 0, 0);
    exp_at(1, K_EX, 4'b1000); exp_at(2, K_MEM, 4'b0000); exp_at(3, K_WB, 4'b0010);
    tick();
    idle();
    repeat (4) tick();

    // MULT then ori held in IF/ID
    drive(OP_R, F_MULT, 1, 0, 0);
    exp_at(0, K_BUSY, 4'd0);
    exp_at(1, K_BUSY, 4'd1); exp_at(2, K_BUSY, 4'd1); exp_at(3, K_BUSY, 4'd1);
    exp_at(4, K_BUSY, 4'd0);
    exp_at(1, K_MUL, 4'd1); exp_at(1, K_EX, 4'b0111); exp_at(4, K_EX, 4'b0111);
    exp_at(2, K_MEM, 4'd0); exp_at(3, K_WB, 4'd0); exp_at(5, K_WB, 4'd0);
    exp_at(6, K_WB, 4'b0010);
    exp_at(1, K_BUSY2, 4'd0); exp_at(1, K_MUL2, 4'd0);
    tick();
    drive(OP_ORI, 6'd0, 1, 0, 0);
    exp_at(4, K_EX, 4'b1100); exp_at(4, K_MUL, 4'd0); exp_at(6, K_WB, 4'b0010);
    repeat (4) tick();
    idle();
    repeat (4) tick();

    // back-to-back MULTs
    drive(OP_R, F_MULT, 1, 0, 0);
    exp_at(6, K_WB, 4'b0010);
    tick();
    exp_at(4, K_MUL, 4'd1); exp_at(4, K_BUSY, 4'd1); exp_at(5, K_BUSY, 4'd1);
    exp_at(6, K_BUSY, 4'd1); exp_at(7, K_BUSY, 4'd0);
    exp_at(6, K_WB, 4'd0); exp_at(8, K_WB, 4'd0); exp_at(9, K_WB, 4'b0010);
    repeat (4) tick();
    idle();
    repeat (7) tick();

    // flush held during MULT busy is ignored
    drive(OP_R, F_MULT, 1, 0, 0);
    exp_at(6, K_WB, 4'b0010);
    tick();
    drive(OP_ORI, 6'd0, 1, 0, 1);
    exp_at(1, K_EX, 4'b0111); exp_at(2, K_EX, 4'b0111); exp_at(2, K_BUSY, 4'd1);
    repeat (3) tick();
    drive(OP_ORI, 6'd0, 1, 0, 0);
    exp_at(1, K_EX, 4'b1100);
    tick();
    idle();
    repeat (4) tick();

    // load-use stall: lw, add(stalled), add
    drive(OP_LW, 6'd0, 1, 0, 0);
    exp_at(1, K_EX, 4'b1000); exp_at(3, K_WB, 4'b0011);
    tick();
    drive(OP_R, F_ADD, 1, 1, 0);
    exp_at(1, K_EX, 4'b0000); exp_at(3, K_WB, 4'b0000);
    tick();
    drive(OP_R, F_ADD, 1, 0, 0);
    exp_at(1, K_EX, 4'b0111); exp_at(3, K_WB, 4'b0010); exp_at(1, K_MUL, 4'd0);
    tick();
    idle();
    repeat (4) tick();

    // beq flushed, beq live, j
    drive(OP_BEQ, 6'd0, 1, 0, 1);
    exp_at(0, K_BR, 4'd0); exp_at(1, K_EX, 4'b0000);
    tick();
    drive(OP_BEQ, 6'd0, 1, 0, 0);
    exp_at(0, K_BR, 4'd1); exp_at(0, K_J, 4'd0); exp_at(1, K_EX, 4'b0010);
    tick();
    drive(OP_J, 6'd0, 1, 0, 0);
    exp_at(0, K_J, 4'd1); exp_at(0, K_BR, 4'd0); exp_at(1, K_EX, 4'b0000);
    tick();
    idle();
    repeat (4) tick();

    // undefined opcode
    drive(OP_BAD, 6'd0, 1, 0, 0);
    exp_at(1, K_ILL, 4'd1); exp_at(1, K_EX, 4'd0); exp_at(2, K_MEM, 4'd0);
    exp_at(3, K_WB, 4'd0); exp_at(2, K_ILL, 4'd0);
    tick();
    idle();
    repeat (4) tick();

    // reset pulsed mid-MULT with cnt=2
    drive(OP_R, F_MULT, 1, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    chk("busy_before_reset", {3'b000, busy_o}, 4'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_busy", {3'b000, busy_o}, 4'd0);
    chk("rst_ex_ctrl", ex_ctrl_o, 4'd0);
    chk("rst_ex_mul", {3'b000, ex_mul_o}, 4'd0);
    chk("rst_mem_ctrl", {2'b00, mem_ctrl_o}, 4'd0);
    chk("rst_wb_ctrl", {2'b00, wb_ctrl_o}, 4'd0);
    rst_i = 1'b0;
    tick();
    exp_at(0, K_WB, 4'd0); exp_at(1, K_WB, 4'd0); exp_at(2, K_WB, 4'd0);
    exp_at(3, K_WB, 4'd0); exp_at(0, K_BUSY, 4'd0); exp_at(1, K_BUSY, 4'd0);
    repeat (6) tick();

    foreach (sb_q[i]) begin
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d actual=never_sampled expected=%b", kname(sb_q[i].kind),
               sb_q[i].cyc, sb_q[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
